lu_pipe: RTL and testbench
==========================

Name: lu_pipe

Overview:
Parametrised, pipelined logic unit and the successor to the 1-bit OR/NOR select mux. It applies one of eight bitwise functions to WIDTH-bit operands and registers the result behind a valid/ready handshake. An accumulator mode chains results: the previous result replaces operand a. A wrap-around counter tracks delivered results. It sits between operand sources and downstream consumers in the LU datapath.

Parameters:
WIDTH, 4, operand and result width in bits (>=1)
CNT_W, 8, width of the delivered-result counter (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand set a/b/op/acc_mode is valid
in_ready  output  1  unit can accept the operand set this cycle
a  input  WIDTH  operand a (ignored when acc_mode=1)
b  input  WIDTH  operand b
op  input  3  function select (encoding below)
acc_mode  input  1  1: use accumulator in place of a
acc_clear  input  1  synchronous accumulator clear
out_valid  output  1  s holds an undelivered result
out_ready  input  1  consumer takes s this cycle
s  output  WIDTH  registered result
count  output  CNT_W  number of results delivered, modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset (at a clk edge with reset=1): s=0, out_valid=0, acc=0, count=0. Reset overrides every other input.
- Reset mid-operation: any pending result is dropped and not counted.
- Handshake:
  - in_ready = ~out_valid | out_ready. This is combinational, with no path from in_valid.
  - accept = in_valid & in_ready.
  - deliver = out_valid & out_ready.
- Output state, a 2-state FSM held in out_valid:
  - EMPTY (out_valid=0): on accept, go to FULL.
  - FULL (out_valid=1): deliver & ~accept goes to EMPTY. deliver & accept stays FULL and loads the new s. ~deliver holds s and stays FULL, with in_ready=0.
- Latency: 1 cycle from accept to out_valid=1. Full throughput is one result per cycle while out_ready=1.
- Operand select: opA = acc_mode ? acc_eff : a. acc_eff = acc_clear ? 0 : acc.
- op encoding, all bitwise over WIDTH:
  - 000 opA|b
  - 001 ~(opA|b)
  - 010 opA&b
  - 011 ~(opA&b)
  - 100 opA^b
  - 101 ~(opA^b)
  - 110 ~opA
  - 111 opA
  - Codes 000/001 reproduce the earlier mux with select=0/1.
- On accept: s <= f(opA, b, op) and acc <= f(opA, b, op). acc updates on every accept, regardless of acc_mode.
- acc_clear without accept: acc <= 0. With accept in the same cycle: the clear applies first (opA=0 in acc_mode), then acc loads the new result.
- Stall: while out_valid=1 and out_ready=0, s and acc are stable and inputs are ignored.
- count increments by 1 on each deliver and wraps from 2^CNT_W-1 to 0. It does not change on accept alone.
- No combinational path from a/b/op to s.

Optional Feature:
- Macro: LU_PIPE_FLAGS_EN.
- Defined: adds outputs zero (1 bit) and parity (1 bit), registered with s on accept.
  - zero = (result == 0).
  - parity = XOR-reduction of result.
  - Both reset to zero=0 and parity=0, and hold during stalls.
- Undefined: the ports do not exist and no flag logic is built.

Test Plan:
All scenarios use WIDTH=4, CNT_W=8.
- Reset: assert reset 2 cycles with in_valid=1 -> s=0000, out_valid=0, count=0, in_ready=1 after release.
- Op sweep: a=1010, b=0110, op=000..111 back-to-back, out_ready=1 -> s=1110,0001,0010,1101,1100,0011,0101,1010, each 1 cycle after accept; count=8.
- Backpressure: accept op=000 a=0001 b=0010, hold out_ready=0 3 cycles -> s=0011 stable, in_ready=0, count unchanged; raise out_ready -> count+1, in_ready=1.
- Accumulator:
  - acc_clear=1 with op=000 b=0001 acc_mode=1 -> s=0001.
  - Then op=000 b=0100 -> s=0101.
  - Then op=100 b=1111 -> s=1010.
  - Then acc_clear alone, then op=111 acc_mode=1 -> s=0000.
- Count wrap and mid-op reset: 256 deliveries -> count=0. Then accept a result, assert reset with out_valid=1 -> out_valid=0 next cycle, count=0, result never delivered.
- With LU_PIPE_FLAGS_EN: a=1010 b=1010 op=100 -> s=0000, zero=1, parity=0; op=000 a=0111 b=0000 -> zero=0, parity=1.

Source files
------------

// File: rtl/lu_pipe_if.sv
// Operand/result handshake bundle for lu_pipe.
// The zero/parity flag signals exist only when LU_PIPE_FLAGS_EN is defined.
interface lu_pipe_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_mode;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] count;
`ifdef LU_PIPE_FLAGS_EN
  logic             zero;
  logic             parity;
`endif

  // Operand source and result consumer side.
  modport master (
    output in_valid, a, b, op, acc_mode, acc_clear, out_ready,
`ifdef LU_PIPE_FLAGS_EN
    input  zero, parity,
`endif
    input  in_ready, out_valid, s, count
  );

  // Logic unit side.
  modport slave (
    input  in_valid, a, b, op, acc_mode, acc_clear, out_ready,
`ifdef LU_PIPE_FLAGS_EN
    output zero, parity,
`endif
    output in_ready, out_valid, s, count
  );
endinterface

// File: rtl/lu_pipe.sv
// lu_pipe: pipelined 8-function bitwise logic unit with a one-deep output
// register, accumulator chaining and a wrap-around delivered-result counter.
// Optional feature macro: LU_PIPE_FLAGS_EN adds registered zero/parity flags.
module lu_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic         clk,
  input logic         reset,
  lu_pipe_if.slave    bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef LU_PIPE_FLAGS_EN
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
`endif

  logic             out_valid;
  logic             in_ready;
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;

  // Handshake qualifiers; in_ready depends only on output state and out_ready.
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = ~out_valid | bus.out_ready;
    accept    = bus.in_valid & in_ready;
    deliver   = out_valid & bus.out_ready;
  end

  // Operand select and bitwise function.
  always_comb begin
    acc_eff = bus.acc_clear ? '0 : acc_q;
    op_a    = bus.acc_mode ? acc_eff : bus.a;
    result  = op_a;
    case (bus.op)
      3'b000:  result = op_a | bus.b;
      3'b001:  result = ~(op_a | bus.b);
      3'b010:  result = op_a & bus.b;
      3'b011:  result = ~(op_a & bus.b);
      3'b100:  result = op_a ^ bus.b;
      3'b101:  result = ~(op_a ^ bus.b);
      3'b110:  result = ~op_a;
      default: result = op_a;
    endcase
  end

  // Next-state: output FSM, result/accumulator load and delivery counter.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    acc_d    = acc_q;
    count_d  = count_q;
`ifdef LU_PIPE_FLAGS_EN
    zero_d   = zero_q;
    parity_d = parity_q;
`endif
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (deliver && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      s_d   = result;
      acc_d = result;
`ifdef LU_PIPE_FLAGS_EN
      zero_d   = (result == '0);
      parity_d = ^result;
`endif
    end else if (bus.acc_clear && in_ready) begin
      acc_d = '0;
    end
    if (deliver) count_d = count_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      s_q      <= '0;
      acc_q    <= '0;
      count_q  <= '0;
`ifdef LU_PIPE_FLAGS_EN
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
`ifdef LU_PIPE_FLAGS_EN
      zero_q   <= zero_d;
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.s         = s_q;
  assign bus.count     = count_q;
`ifdef LU_PIPE_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
`endif

endmodule

// File: tb/tb_lu_pipe.sv
// Directed self-checking bench for lu_pipe (WIDTH=4, CNT_W=8).
module tb_lu_pipe;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  lu_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  lu_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_exp [8];

  initial begin
    total = 0;
    bad   = 0;
    sweep_exp[0] = 4'b1110; sweep_exp[1] = 4'b0001;
    sweep_exp[2] = 4'b0010; sweep_exp[3] = 4'b1101;
    sweep_exp[4] = 4'b1100; sweep_exp[5] = 4'b0011;
    sweep_exp[6] = 4'b0101; sweep_exp[7] = 4'b1010;

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 4'b1111;
    bus.b         = 4'b1111;
    bus.op        = 3'b000;
    bus.acc_mode  = 1'b0;
    bus.acc_clear = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted.
    tick();
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_s",         32'(bus.s),         32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_count",     32'(bus.count),     32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);
`ifdef LU_PIPE_FLAGS_EN
    check("rst_zero",   32'(bus.zero),   32'h0);
    check("rst_parity", 32'(bus.parity), 32'h0);
`endif

    // Op sweep back-to-back at full throughput.
    bus.out_ready = 1'b1;
    bus.a = 4'b1010;
    bus.b = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      bus.op       = 3'(i);
      bus.in_valid = 1'b1;
      tick();
      check($sformatf("sweep_s_op%0d", i), 32'(bus.s), 32'(sweep_exp[i]));
      check($sformatf("sweep_ov_op%0d", i), 32'(bus.out_valid), 32'h1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("sweep_count", 32'(bus.count),     32'd8);
    check("sweep_drain", 32'(bus.out_valid), 32'h0);

    // Backpressure: result must hold and new operands must be ignored.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 3'b000;
    bus.a         = 4'b0001;
    bus.b         = 4'b0010;
    tick();
    check("bp_first_s", 32'(bus.s), 32'h3);
    bus.a  = 4'b1111;
    bus.op = 3'b101;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_s_%0d", i),        32'(bus.s),        32'h3);
      check($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), 32'h0);
      check($sformatf("bp_count_%0d", i),    32'(bus.count),    32'd8);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_release_count", 32'(bus.count),     32'd9);
    check("bp_release_ov",    32'(bus.out_valid), 32'h0);

    // Accumulator chaining (acc currently holds 0011 from the stalled result).
    bus.in_valid  = 1'b1;
    bus.acc_mode  = 1'b1;
    bus.acc_clear = 1'b1;
    bus.a         = 4'b1111;
    bus.op        = 3'b000;
    bus.b         = 4'b0001;
    tick();
    check("acc_clear_or", 32'(bus.s), 32'h1);
    bus.acc_clear = 1'b0;
    bus.b         = 4'b0100;
    tick();
    check("acc_or", 32'(bus.s), 32'h5);
    bus.op = 3'b100;
    bus.b  = 4'b1111;
    tick();
    check("acc_xor", 32'(bus.s), 32'hA);
    bus.in_valid  = 1'b0;
    bus.acc_clear = 1'b1;
    tick();
    bus.acc_clear = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 3'b111;
    tick();
    check("acc_after_clear", 32'(bus.s), 32'h0);
    bus.in_valid = 1'b0;
    bus.acc_mode = 1'b0;
    tick();
    check("acc_count", 32'(bus.count), 32'd13);

    // Counter wrap from a fresh reset: 256 deliveries return count to 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrap_start", 32'(bus.count), 32'h0);
    bus.in_valid = 1'b1;
    bus.op       = 3'b000;
    bus.a        = 4'b0001;
    bus.b        = 4'b0000;
    for (int i = 0; i < 256; i++) tick();
    check("wrap_255", 32'(bus.count), 32'd255);
    bus.in_valid = 1'b0;
    tick();
    check("wrap_0", 32'(bus.count), 32'd0);

    // Reset with a pending result drops it uncounted.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    check("midrst_pending", 32'(bus.out_valid), 32'h1);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ov",    32'(bus.out_valid), 32'h0);
    check("midrst_count", 32'(bus.count),     32'h0);
    bus.out_ready = 1'b1;
    tick();
    check("midrst_not_delivered", 32'(bus.count), 32'h0);

`ifdef LU_PIPE_FLAGS_EN
    // Zero and parity flags registered with s.
    bus.in_valid = 1'b1;
    bus.acc_mode = 1'b0;
    bus.a  = 4'b1010;
    bus.b  = 4'b1010;
    bus.op = 3'b100;
    tick();
    check("flag_s0",     32'(bus.s),      32'h0);
    check("flag_zero1",  32'(bus.zero),   32'h1);
    check("flag_par0",   32'(bus.parity), 32'h0);
    bus.a  = 4'b0111;
    bus.b  = 4'b0000;
    bus.op = 3'b000;
    tick();
    check("flag_s7",     32'(bus.s),      32'h7);
    check("flag_zero0",  32'(bus.zero),   32'h0);
    check("flag_par1",   32'(bus.parity), 32'h1);
    bus.in_valid = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
